// File: rtl/prime_printer_pkg.sv
// rtl/prime_printer_pkg.sv - shared states, ASCII constants and sizing helpers for prime_printer.
package prime_printer_pkg;

    typedef enum logic [1:0] {IDLE, CONV, SEND, TERM} state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int digits(input int width);
        if (width <= 8)       return 3;
        else if (width <= 16) return 5;
        else                  return 10;
    endfunction

    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/prime_printer_if.sv
// rtl/prime_printer_if.sv - valid/ready prime transfer bus between primogen and prime_printer.
interface prime_printer_if #(parameter int WIDTH = 16) ();
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             error;
    logic             ready;

    modport master (output valid, output data, output error, input ready);
    modport slave  (input valid, input data, input error, output ready);
endinterface

// File: rtl/prime_printer_uart_tx_byte.sv
// rtl/prime_printer_uart_tx_byte.sv - 8N1 byte transmitter; start may coincide with done for gapless frames.
module uart_tx_byte #(
    parameter int DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_done,
    output logic       o_tx
);
    localparam int BW = $clog2(DIV);

    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_busy;
    logic          r_tx;
    logic          w_tick;

    assign w_tick = r_busy && (r_baud == BW'(DIV - 1));
    assign o_done = w_tick && (r_bit == 4'd9);
    assign o_tx   = r_tx;

    // r_bit counts the bit currently on the line: 0 = start, 1..8 = data, 9 = stop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
        end else if (i_start && (!r_busy || o_done)) begin
            r_shift <= {1'b1, i_byte};
            r_tx    <= 1'b0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_busy  <= 1'b1;
        end else if (o_done) begin
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
            r_bit   <= '0;
            r_baud  <= '0;
        end else if (w_tick) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[8:1]};
            r_bit   <= r_bit + 4'd1;
        end else if (r_busy) begin
            r_baud  <= r_baud + 1'b1;
        end
    end

endmodule

// File: rtl/prime_printer.sv
// rtl/prime_printer.sv - prints each accepted prime as a decimal ASCII line over UART 8N1.
// Build option: PRIME_PRINTER_CRLF_EN selects a CR LF terminator instead of LF.
module prime_printer
    import prime_printer_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic           clk,
    input  logic           rst,
    prime_printer_if.slave bus,
    output logic           o_tx,
    output logic           o_busy
);
    localparam int DIGITS = digits(WIDTH);
    localparam int DIV    = baud_div(CLK_HZ, BAUD);
    localparam int IW     = $clog2(DIGITS);
    localparam int CW     = $clog2(WIDTH);
`ifdef PRIME_PRINTER_CRLF_EN
    localparam logic [7:0] TERM_FIRST = ASCII_CR;
    localparam bit         TERM_TWO   = 1'b1;
`else
    localparam logic [7:0] TERM_FIRST = ASCII_LF;
    localparam bit         TERM_TWO   = 1'b0;
`endif

    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_bcd, w_bcd_adj, w_bcd_shift;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx, w_msd;
    logic                r_err, r_first, r_lf_sent;
    logic                w_start, w_done, w_ready, w_last_conv;
    logic [7:0]          w_byte;

    function automatic logic [7:0] char_at(input logic [4*DIGITS-1:0] bcd,
                                           input logic err, input logic [IW-1:0] idx);
        if (err) return (idx == IW'(2)) ? ASCII_E : ASCII_R;
        return ASCII_0 + {4'd0, bcd[4*idx +: 4]};
    endfunction

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++)
            if (r_bcd[4*i +: 4] > 4'd4) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        w_bcd_shift = {w_bcd_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
        // index of the most significant nonzero digit; 0 also covers the value zero
        w_msd = '0;
        for (int i = 0; i < DIGITS; i++)
            if (w_bcd_shift[4*i +: 4] != 4'd0) w_msd = IW'(i);
    end

    assign w_last_conv = (r_cnt == CW'(WIDTH - 1));
    assign w_ready     = (r_state == IDLE);
    assign bus.ready   = w_ready;
    assign o_busy      = !w_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_byte  = TERM_FIRST;
        unique case (r_state)
            IDLE: if (bus.valid) w_next = bus.error ? SEND : CONV;
            CONV: if (w_last_conv) w_next = SEND;
            SEND: begin
                if (r_first) begin
                    w_start = 1'b1;
                    w_byte  = char_at(r_bcd, r_err, r_idx);
                end else if (w_done) begin
                    w_start = 1'b1;
                    if (r_idx != '0) begin
                        w_byte = char_at(r_bcd, r_err, r_idx - 1'b1);
                    end else begin
                        w_byte = TERM_FIRST;
                        w_next = TERM;
                    end
                end
            end
            TERM: begin
                if (w_done) begin
                    if (TERM_TWO && !r_lf_sent) begin
                        w_start = 1'b1;
                        w_byte  = ASCII_LF;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_first   <= 1'b0;
            r_lf_sent <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.valid) begin
                    r_bin     <= bus.data;
                    r_bcd     <= '0;
                    r_cnt     <= '0;
                    r_err     <= bus.error;
                    r_idx     <= IW'(2);
                    r_first   <= 1'b1;
                    r_lf_sent <= 1'b0;
                end
                CONV: begin
                    r_bcd <= w_bcd_shift;
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_conv) r_idx <= w_msd;
                end
                SEND: begin
                    r_first <= 1'b0;
                    if (!r_first && w_done && r_idx != '0) r_idx <= r_idx - 1'b1;
                end
                TERM: if (w_done) r_lf_sent <= 1'b1;
                default: ;
            endcase
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_uart (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_byte  (w_byte),
        .o_done  (w_done),
        .o_tx    (o_tx)
    );

endmodule

// File: tb/tb_prime_printer.sv
// tb/tb_prime_printer.sv - randomized self-checking bench for prime_printer, decoding the UART line.
module tb_prime_printer;
    localparam int DIV = 104;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy;
    int   cyc = 0;
    int   n_err = 0;
    int   n_chk = 0;
`ifdef PRIME_PRINTER_CRLF_EN
    string term_s = "\r\n";
`else
    string term_s = "\n";
`endif

    prime_printer_if #(.WIDTH(16)) bus ();

    prime_printer #(.WIDTH(16), .CLK_HZ(12000000), .BAUD(115200)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .o_tx   (tx),
        .o_busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string line_of(input int v, input bit e);
        if (e) return {"ERR", term_s};
        return {$sformatf("%0d", v), term_s};
    endfunction

    // present one transfer; t returns the accepting edge index
    task automatic send(input logic [15:0] d, input logic e, output int t);
        @(negedge clk);
        chk("ready_before_send", bus.ready, 1);
        bus.valid = 1'b1;
        bus.data  = d;
        bus.error = e;
        @(posedge clk);
        @(negedge clk);
        t = cyc;
        bus.valid = 1'b0;
        chk("ready_after_accept", bus.ready, 0);
        chk("busy_after_accept", busy, 1);
    endtask

    // decode a whole line at fixed bit positions from the first start bit, so any gap shows up
    task automatic get_line(input string exp, input int t_first);
        int s, n, e;
        logic [9:0] fr;
        bit seen;
        seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1;
        end
        chk("first_start_edge", seen ? cyc : -1, t_first);
        if (!seen) return;
        s = cyc;
        n = exp.len();
        for (int c = 0; c < n; c++) begin
            for (int b = 0; b < 10; b++) begin
                while (cyc < s + c*10*DIV + b*DIV + DIV/2) @(negedge clk);
                fr[b] = tx;
            end
            chk($sformatf("framing_c%0d", c), {30'd0, fr[9], fr[0]}, 32'd2);
            chk($sformatf("char_c%0d", c), {24'd0, fr[8:1]}, {24'd0, exp[c]});
        end
        e = s + n*10*DIV;
        while (cyc < e - 1) @(negedge clk);
        chk("ready_low_before_end", bus.ready, 0);
        @(negedge clk);
        chk("ready_at_line_end", bus.ready, 1);
        chk("tx_idle_at_line_end", tx, 1);
    endtask

    task automatic print_one(input logic [15:0] d, input logic e);
        int t;
        send(d, e, t);
        get_line(line_of(int'(d), e), e ? t + 1 : t + 17);
    endtask

    initial begin
        int t1, t2;
        logic [15:0] v1, v2;
        bus.valid = 1'b0;
        bus.data  = '0;
        bus.error = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", bus.ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_tx", tx, 1);
        rst = 1'b0;

        print_one(16'd17, 1'b0);
        print_one(16'd0, 1'b0);
        print_one(16'd65521, 1'b0);
        print_one(16'd5, 1'b1);
        for (int i = 0; i < 2; i++) print_one(16'($urandom_range(0, 65535)), 1'b0);

        // busy: valid held with churning data, then a transfer in the cycle ready rises
        v1 = 16'($urandom_range(1000, 65535));
        v2 = 16'($urandom_range(0, 999));
        send(v1, 1'b0, t1);
        fork
            get_line(line_of(int'(v1), 1'b0), t1 + 17);
            begin
                bus.valid = 1'b1;
                for (int k = 0; k < 20000 && bus.ready !== 1'b1; k++) begin
                    bus.data  = 16'($urandom);
                    bus.error = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                bus.data  = v2;
                bus.error = 1'b0;
                @(posedge clk);
                @(negedge clk);
                t2 = cyc;
                bus.valid = 1'b0;
            end
        join
        chk("b2b_ready_low", bus.ready, 0);
        get_line(line_of(int'(v2), 1'b0), t2 + 17);

        // reset during data bit 2 of the first character of "123"
        send(16'd123, 1'b0, t1);
        while (cyc < t1 + 17 + 3*DIV + DIV/2) @(negedge clk);
        chk("tx_mid_d2", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_ready", bus.ready, 1);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        print_one(16'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
